// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states,
// RV32I width codes and response error codes.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_RANGE    = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Lane steering: extracts/extends the addressed load lane and merges a
// byte/half store lane into a full memory word. Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{addr, 3'b000} +: 8];
        half_v = addr[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_val = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_val = {24'h0, byte_v};
            F3_H:    load_val = {{16{half_v[15]}}, half_v};
            F3_HU:   load_val = {16'h0, half_v};
            F3_W:    load_val = rdata;
            default: load_val = 32'h0;
        endcase

        // Sub-word stores keep every byte of rdata except the target lane.
        store_word = rdata;
        case (funct3[1:0])
            2'b00:   store_word[{addr, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   store_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-wide memory with
// combinational read; sub-word stores use read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] BYTE_LIMIT = 32'(WORDS * 4);

    lsu_state_t  state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;

    logic        accept;
    logic        f3_legal;
    logic        misalign;
    logic        out_of_range;
    logic [1:0]  req_err;
    logic [31:0] align_rdata;
    logic [31:0] load_val;
    logic [31:0] store_word;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        f3_legal = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = !req_we;
            default:          f3_legal = 1'b0;
        endcase
        misalign     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = (req_addr >= BYTE_LIMIT);
        if (!f3_legal)
            req_err = ERR_ILLEGAL;
        else if (misalign)
            req_err = ERR_MISALIGN;
        else if (out_of_range)
            req_err = ERR_RANGE;
        else
            req_err = ERR_NONE;
    end

    // Loads extend straight from memory; stores merge over the captured word.
    assign align_rdata = (state == LOAD) ? mem_rdata : merge_q;

    lsu_align u_align (
        .funct3     (f3_q),
        .addr       (addr_q[1:0]),
        .rdata      (align_rdata),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    assign mem_addr  = (state == LOAD || state == READ || state == WRITE)
                       ? {2'b00, addr_q[31:2]} : 32'h0;
    assign mem_we    = (state == WRITE) && !rst;
    assign mem_wdata = (state == WRITE) ? store_word : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            merge_q   <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= ERR_NONE;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (req_err != ERR_NONE) begin
                            rsp_err   <= req_err;
                            rsp_rdata <= 32'h0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else if (!req_we)
                            state <= LOAD;
                        else if (req_funct3 == F3_W)
                            state <= WRITE;
                        else
                            state <= READ;
                    end
                end
                LOAD: begin
                    rsp_rdata <= load_val;
                    rsp_err   <= ERR_NONE;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                READ: begin
                    merge_q <= mem_rdata;
                    state   <= WRITE;
                end
                WRITE: begin
                    rsp_rdata <= 32'h0;
                    rsp_err   <= ERR_NONE;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // we_q is kept for debug visibility of the accepted request direction.
    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a behavioural word memory
// with combinational read and synchronous write.
module tb_load_store_unit;

    localparam int WORDS = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [WORDS];
    int          we_cnt = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.WORDS(WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = (mem_addr < 32'(WORDS)) ? mem[mem_addr[5:0]] : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_addr < 32'(WORDS))
                mem[mem_addr[5:0]] <= mem_wdata;
            we_cnt     <= we_cnt + 1;
            last_waddr <= mem_addr;
            last_wdata <= mem_wdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge in IDLE; returns latency in edges
    // from acceptance to the response pulse, plus the response payload.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic [1:0] er);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        chk({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_hold"}, rsp_rdata, rd);
    endtask

    int          lat;
    logic [31:0] rd;
    logic [1:0]  er;
    int          w0;

    logic        bwe   [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  bf3   [3] = '{3'b010, 3'b010, 3'b000};
    logic [31:0] baddr [3] = '{32'h4, 32'hC, 32'hC};
    logic [31:0] bwd   [3] = '{32'h0, 32'h12345678, 32'h0};
    logic [31:0] bexp  [3] = '{32'hCAFEAABB, 32'h0, 32'h00000078};
    int          acc_cyc [3] = '{0, 0, 0};
    int          nacc;
    int          nresp;
    int          idx;
    logic        acc;

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h0;
        mem[1] = 32'h8899AABB;
        mem[2] = 32'h11223344;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        do_req("lb", 1'b0, 3'b000, 32'h5, 32'h0, lat, rd, er);
        chk("lb_rdata", rd, 32'hFFFFFFAA);
        chk("lb_err", 32'(er), 32'd0);
        chk("lb_lat", 32'(lat), 32'd2);

        do_req("lbu", 1'b0, 3'b100, 32'h5, 32'h0, lat, rd, er);
        chk("lbu_rdata", rd, 32'h000000AA);

        w0 = we_cnt;
        do_req("sb", 1'b1, 3'b000, 32'hA, 32'h000000EE, lat, rd, er);
        chk("sb_wcount", 32'(we_cnt - w0), 32'd1);
        chk("sb_waddr", last_waddr, 32'd2);
        chk("sb_wdata", last_wdata, 32'h11EE3344);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_rdata", rd, 32'h0);
        chk("sb_err", 32'(er), 32'd0);

        do_req("sh", 1'b1, 3'b001, 32'h6, 32'h0000CAFE, lat, rd, er);
        chk("sh_mem1", mem[1], 32'hCAFEAABB);

        do_req("lh", 1'b0, 3'b001, 32'h6, 32'h0, lat, rd, er);
        chk("lh_rdata", rd, 32'hFFFFCAFE);
        do_req("lhu", 1'b0, 3'b101, 32'h6, 32'h0, lat, rd, er);
        chk("lhu_rdata", rd, 32'h0000CAFE);
        do_req("lw", 1'b0, 3'b010, 32'h8, 32'h0, lat, rd, er);
        chk("lw_rdata", rd, 32'h11EE3344);

        w0 = we_cnt;
        do_req("lw_mis", 1'b0, 3'b010, 32'h3, 32'h0, lat, rd, er);
        chk("lw_mis_err", 32'(er), 32'd1);
        chk("lw_mis_rdata", rd, 32'h0);
        chk("lw_mis_lat", 32'(lat), 32'd1);
        do_req("ill", 1'b0, 3'b011, 32'h3, 32'h0, lat, rd, er);
        chk("ill_err", 32'(er), 32'd3);
        do_req("sw_rng", 1'b1, 3'b010, 32'h100, 32'hFFFFFFFF, lat, rd, er);
        chk("sw_rng_err", 32'(er), 32'd2);
        chk("sw_rng_rdata", rd, 32'h0);
        chk("err_no_write", 32'(we_cnt - w0), 32'd0);

        // Reset lands while an SB is in WRITE: the write must be suppressed.
        w0 = we_cnt;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h8;
        req_wdata  = 32'h00000055;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmw_read_addr", mem_addr, 32'd2);
        @(negedge clk);
        chk("rmw_write_we", 32'(mem_we), 32'd1);
        chk("rmw_write_data", mem_wdata, 32'h11EE3355);
        rst = 1'b1;
        #1;
        chk("rst_forces_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        chk("rst2_ready", 32'(req_ready), 32'd1);
        chk("rst2_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst2_rdata", rsp_rdata, 32'h0);
        chk("rst2_err", 32'(rsp_err), 32'd0);
        chk("rst2_mem_addr", mem_addr, 32'h0);
        chk("rst2_mem_wdata", mem_wdata, 32'h0);
        chk("rst2_no_write", 32'(we_cnt - w0), 32'd0);
        chk("rst2_mem2", mem[2], 32'h11EE3344);
        rst = 1'b0;
        req_we = 1'b0;
        @(negedge clk);
        do_req("lw_after", 1'b0, 3'b010, 32'h8, 32'h0, lat, rd, er);
        chk("lw_after_rdata", rd, 32'h11EE3344);
        chk("lw_after_lat", 32'(lat), 32'd2);

        // Back-to-back with req_valid held high throughout.
        nacc  = 0;
        nresp = 0;
        idx   = 0;
        req_valid  = 1'b1;
        req_we     = bwe[0];
        req_funct3 = bf3[0];
        req_addr   = baddr[0];
        req_wdata  = bwd[0];
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid) begin
                if (nresp < 3) begin
                    chk($sformatf("b2b_rdata%0d", nresp), rsp_rdata, bexp[nresp]);
                    chk($sformatf("b2b_err%0d", nresp), 32'(rsp_err), 32'd0);
                end
                nresp++;
            end
            acc = req_valid && req_ready;
            if (acc) begin
                if (nacc < 3) acc_cyc[nacc] = c;
                nacc++;
            end
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    req_we     = bwe[idx];
                    req_funct3 = bf3[idx];
                    req_addr   = baddr[idx];
                    req_wdata  = bwd[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        chk("b2b_accepts", 32'(nacc), 32'd3);
        chk("b2b_resps", 32'(nresp), 32'd3);
        chk("b2b_gap_lw", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        chk("b2b_gap_sw", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        chk("b2b_mem3", mem[3], 32'h12345678);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
